// File: rtl/exec_cc_stage.sv
// Execute-stage back end: condition-code register, branch/cmov condition evaluation
// and a one-entry valid/ready slot toward the memory stage.
module exec_cc_stage #(
    parameter int unsigned W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   in_icode,
    input  logic [3:0]   in_ifun,
    input  logic [W-1:0] in_alua,
    input  logic [W-1:0] in_alub,
    input  logic [W-1:0] in_vale,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [3:0]   out_icode,
    output logic [W-1:0] out_vale,
    output logic         out_cnd,
    output logic         out_err,
    output logic         cc_zf,
    output logic         cc_sf,
    output logic         cc_of
);
    localparam logic [3:0] IC_CMOV = 4'd2;
    localparam logic [3:0] IC_OPQ  = 4'd6;
    localparam logic [3:0] IC_JXX  = 4'd7;

    logic accept_c;
    logic is_opq_c;
    logic is_cond_c;
    logic illegal_c;
    logic cc_wr_c;
    logic cond_c;
    logic cnd_c;
    logic zf_c;
    logic sf_c;
    logic of_c;
    logic unused_ok_c;

    // Only operand sign bits feed the overflow logic.
    assign unused_ok_c = ^{in_alua[W-2:0], in_alub[W-2:0]};

    // Full throughput: a draining slot can be refilled in the same cycle.
    assign in_ready = !out_valid || out_ready;

    // Accept, legality, condition (from pre-update flags) and new flag values.
    always_comb begin
        accept_c  = in_valid && in_ready && !flush;
        is_opq_c  = (in_icode == IC_OPQ);
        is_cond_c = (in_icode == IC_CMOV) || (in_icode == IC_JXX);
        illegal_c = (is_opq_c && (in_ifun > 4'd3)) || (is_cond_c && (in_ifun > 4'd6));
        cc_wr_c   = accept_c && is_opq_c && !illegal_c;

        cond_c = 1'b0;
        case (in_ifun)
            4'd0:    cond_c = 1'b1;
            4'd1:    cond_c = (cc_sf ^ cc_of) | cc_zf;
            4'd2:    cond_c = cc_sf ^ cc_of;
            4'd3:    cond_c = cc_zf;
            4'd4:    cond_c = ~cc_zf;
            4'd5:    cond_c = ~(cc_sf ^ cc_of);
            4'd6:    cond_c = ~(cc_sf ^ cc_of) & ~cc_zf;
            default: cond_c = 1'b0;
        endcase
        cnd_c = is_cond_c && !illegal_c && cond_c;

        zf_c = (in_vale == '0);
        sf_c = in_vale[W-1];
        of_c = 1'b0;
        case (in_ifun)
            4'd0:    of_c = (in_alua[W-1] == in_alub[W-1]) && (in_vale[W-1] != in_alua[W-1]);
            4'd1:    of_c = (in_alua[W-1] != in_alub[W-1]) && (in_vale[W-1] != in_alub[W-1]);
            default: of_c = 1'b0;
        endcase
    end

    // Slot and condition-code registers; data regs hold when the slot drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_icode <= 4'd0;
            out_vale  <= '0;
            out_cnd   <= 1'b0;
            out_err   <= 1'b0;
            cc_zf     <= 1'b1;
            cc_sf     <= 1'b0;
            cc_of     <= 1'b0;
        end else begin
            if (accept_c) begin
                out_valid <= 1'b1;
                out_icode <= in_icode;
                out_vale  <= in_vale;
                out_cnd   <= cnd_c;
                out_err   <= illegal_c;
            end else if (out_ready || flush) begin
                out_valid <= 1'b0;
            end
            if (cc_wr_c) begin
                cc_zf <= zf_c;
                cc_sf <= sf_c;
                cc_of <= of_c;
            end
        end
    end
endmodule

// File: tb/tb_exec_cc_stage.sv
// Self-checking bench for exec_cc_stage: directed scenarios then randomized traffic,
// compared against a transaction-level model using wide signed arithmetic for flags.
module tb_exec_cc_stage;
    localparam int unsigned W = 64;

    logic         clk = 1'b0;
    logic         rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [3:0]   in_icode, in_ifun, out_icode;
    logic [W-1:0] in_alua, in_alub, in_vale, out_vale;
    logic         out_cnd, out_err, cc_zf, cc_sf, cc_of;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic         m_valid, m_cnd, m_err, m_zf, m_sf, m_of;
    logic [3:0]   m_icode;
    logic [W-1:0] m_vale;

    exec_cc_stage #(.W(W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_icode(in_icode), .in_ifun(in_ifun),
        .in_alua(in_alua), .in_alub(in_alub), .in_vale(in_vale),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_icode(out_icode), .out_vale(out_vale),
        .out_cnd(out_cnd), .out_err(out_err),
        .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ALU result as the upstream ALU would produce it (sub is B-A).
    function automatic logic [W-1:0] alu(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        case (f)
            4'd0:    return b + a;
            4'd1:    return b - a;
            4'd2:    return b & a;
            4'd3:    return b ^ a;
            default: return b;
        endcase
    endfunction

    // Signed overflow: the true W+1-bit result does not fit in W bits.
    function automatic logic ovf(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [W:0] r;
        r = '0;
        if (f == 4'd0) r = $signed({a[W-1], a}) + $signed({b[W-1], b});
        if (f == 4'd1) r = $signed({b[W-1], b}) - $signed({a[W-1], a});
        return r[W] != r[W-1];
    endfunction

    function automatic logic cond_model(input logic [3:0] f, input logic zf, input logic sf, input logic of);
        logic less;
        less = (sf != of);
        case (f)
            4'd0:    return 1'b1;
            4'd1:    return less || zf;
            4'd2:    return less;
            4'd3:    return zf;
            4'd4:    return !zf;
            4'd5:    return !less;
            4'd6:    return !less && !zf;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".valid"}, W'(out_valid), W'(m_valid));
        check({tag, ".icode"}, W'(out_icode), W'(m_icode));
        check({tag, ".vale"},  out_vale, m_vale);
        check({tag, ".cnd"},   W'(out_cnd), W'(m_cnd));
        check({tag, ".err"},   W'(out_err), W'(m_err));
        check({tag, ".zf"},    W'(cc_zf), W'(m_zf));
        check({tag, ".sf"},    W'(cc_sf), W'(m_sf));
        check({tag, ".of"},    W'(cc_of), W'(m_of));
    endtask

    // One clock: drive inputs, check in_ready, advance model, check registered outputs.
    task automatic cycle(input string tag, input logic r, input logic iv, input logic [3:0] ic,
                         input logic [3:0] fn, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] e, input logic ordy, input logic fl);
        logic rdy, acc, is_op, is_cc, bad;
        rst = r; in_valid = iv; in_icode = ic; in_ifun = fn;
        in_alua = a; in_alub = b; in_vale = e; out_ready = ordy; flush = fl;
        #1;
        rdy = !m_valid || ordy;
        check({tag, ".in_ready"}, W'(in_ready), W'(rdy));
        is_op = (ic == 4'd6);
        is_cc = (ic == 4'd2) || (ic == 4'd7);
        bad   = (is_op && fn > 4'd3) || (is_cc && fn > 4'd6);
        acc   = iv && rdy && !fl;
        if (r) begin
            m_valid = 0; m_icode = 0; m_vale = 0; m_cnd = 0; m_err = 0;
            m_zf = 1; m_sf = 0; m_of = 0;
        end else if (acc) begin
            m_valid = 1; m_icode = ic; m_vale = e; m_err = bad;
            m_cnd = is_cc && !bad && cond_model(fn, m_zf, m_sf, m_of);
            if (is_op && !bad) begin
                m_zf = (e == 0);
                m_sf = ($signed(e) < 0);
                m_of = ovf(fn, a, b);
            end
        end else if (ordy || fl) begin
            m_valid = 0;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    localparam logic [W-1:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;

    initial begin
        m_valid = 0; m_icode = 0; m_vale = 0; m_cnd = 0; m_err = 0;
        m_zf = 1; m_sf = 0; m_of = 0;
        rst = 1; flush = 0; in_valid = 0; in_icode = 0; in_ifun = 0;
        in_alua = 0; in_alub = 0; in_vale = 0; out_ready = 1;
        #2;

        cycle("reset", 1, 0, 0, 0, 0, 0, 0, 1, 0);
        check("reset.zf_lit", W'(cc_zf), W'(1'b1));
        cycle("idle", 0, 0, 0, 0, 0, 0, 0, 1, 0);
        check("idle.in_ready_lit", W'(in_ready), W'(1'b1));

        cycle("opq_and", 0, 1, 6, 2, 64'h3FF, 64'h368, 64'h368, 1, 0);
        check("opq_and.vale_lit", out_vale, 64'h368);

        cycle("opq_add_ovf", 0, 1, 6, 0, MAXP, MAXP, 64'hFFFF_FFFF_FFFF_FFFE, 1, 0);
        check("opq_add_ovf.flags_lit", W'({cc_zf, cc_sf, cc_of}), W'(3'b011));
        cycle("jl", 0, 1, 7, 2, 0, 0, 0, 1, 0);
        check("jl.cnd_lit", W'(out_cnd), W'(1'b0));
        cycle("jle", 0, 1, 7, 1, 0, 0, 0, 1, 0);
        cycle("jne", 0, 1, 7, 4, 0, 0, 0, 1, 0);
        check("jne.cnd_lit", W'(out_cnd), W'(1'b1));

        cycle("opq_sub_zero", 0, 1, 6, 1, 5, 5, 0, 1, 0);
        cycle("cmove", 0, 1, 2, 3, 0, 0, 64'h1234, 1, 0);
        check("cmove.cnd_lit", W'(out_cnd), W'(1'b1));

        for (int i = 0; i < 3; i++)
            cycle("stall", 0, 1, 6, 0, 64'd1, 64'd2, 64'd3, 0, 0);
        for (int i = 0; i < 4; i++)
            cycle("release", 0, 1, 7, 4'(i), 0, 0, 64'(i + 100), 1, 0);

        cycle("flush_xor", 0, 1, 6, 3, 64'hAA, 64'hAA, 0, 1, 1);
        cycle("opq_bad_ifun", 0, 1, 6, 7, 1, 2, 3, 1, 0);
        check("opq_bad_ifun.err_lit", W'(out_err), W'(1'b1));
        cycle("jxx_bad_ifun", 0, 1, 7, 9, 0, 0, 0, 1, 0);
        cycle("fill", 0, 1, 6, 0, 64'd7, 64'd9, 64'd16, 0, 0);
        cycle("mid_reset", 1, 1, 6, 0, 64'd1, 64'd1, 64'd2, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [3:0]   ic, fn;
            logic [W-1:0] a, b, e;
            case ($urandom_range(0, 3))
                0: ic = 4'd2;
                1, 2: ic = 4'd6;
                default: ic = ($urandom_range(0, 1) == 0) ? 4'd7 : 4'($urandom_range(0, 15));
            endcase
            fn = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6));
            if ($urandom_range(0, 2) == 0) begin
                a = W'($urandom_range(0, 3));
                b = W'($urandom_range(0, 3));
            end else begin
                a = {$urandom(), $urandom()};
                b = {$urandom(), $urandom()};
            end
            e = (ic == 4'd6) ? alu(fn, a, b) : {$urandom(), $urandom()};
            cycle("rand", ($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), ic, fn, a, b, e,
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
